// File: rtl/pll_lock_supervisor.sv
// Reset/lock sequencer for a Gowin rPLL: pulses the PLL reset, qualifies lock with a
// timeout and bounded retries, then releases downstream reset channels one by one.
module pll_lock_supervisor #(
    parameter int NUM_CH         = 3,
    parameter int PLL_RST_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 27000,
    parameter int STABLE_CYCLES  = 2700,
    parameter int MAX_RETRIES    = 4,
    parameter int CH_STAGGER     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lock,
    input  logic              relock_req,
    output logic              pll_reset,
    output logic [NUM_CH-1:0] rst_out,
    output logic              ready,
    output logic              fail,
    output logic [3:0]        retry_cnt
);

    localparam int REL_MAX = (NUM_CH - 1) * CH_STAGGER;
    localparam int RST_W   = $clog2(PLL_RST_CYCLES + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int STB_W   = $clog2(STABLE_CYCLES + 1);
    localparam int REL_W   = (REL_MAX < 1) ? 1 : $clog2(REL_MAX + 1);

    localparam logic [RST_W-1:0] RST_LAST    = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX      = TO_W'(TIMEOUT_CYCLES);
    localparam logic [STB_W-1:0] STB_MAX     = STB_W'(STABLE_CYCLES);
    localparam logic [REL_W-1:0] REL_LAST    = REL_W'(REL_MAX);
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t state, state_n;

    logic              lock_meta, lock_s;
    logic [RST_W-1:0]  rst_cnt, rst_cnt_n;
    logic [TO_W-1:0]   to_cnt, to_cnt_n, to_inc;
    logic [STB_W-1:0]  stb_cnt, stb_cnt_n, stb_inc;
    logic [REL_W-1:0]  rel_cnt, rel_cnt_n, rel_inc;
    logic [3:0]        retry_n, retry_sat;
    logic [NUM_CH-1:0] rst_out_n;
    logic              ready_n;
    logic              go_rst, go_rel, go_run;

    assign to_inc    = (to_cnt == TO_MAX) ? to_cnt : to_cnt + TO_W'(1);
    assign stb_inc   = (stb_cnt == STB_MAX) ? stb_cnt : stb_cnt + STB_W'(1);
    assign rel_inc   = rel_cnt + REL_W'(1);
    assign retry_sat = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            state     <= S_PLL_RST;
            rst_cnt   <= '0;
            to_cnt    <= '0;
            stb_cnt   <= '0;
            rel_cnt   <= '0;
            pll_reset <= 1'b1;
            rst_out   <= '1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= '0;
        end else begin
            lock_meta <= lock;
            lock_s    <= lock_meta;
            state     <= state_n;
            rst_cnt   <= rst_cnt_n;
            to_cnt    <= to_cnt_n;
            stb_cnt   <= stb_cnt_n;
            rel_cnt   <= rel_cnt_n;
            pll_reset <= (state_n == S_PLL_RST) || (state_n == S_FAIL);
            rst_out   <= rst_out_n;
            ready     <= ready_n;
            fail      <= (state_n == S_FAIL);
            retry_cnt <= retry_n;
        end
    end

    // Outputs are decoded from the next state so every output is a plain register.
    always_comb begin
        state_n   = state;
        rst_cnt_n = rst_cnt;
        to_cnt_n  = to_cnt;
        stb_cnt_n = stb_cnt;
        rel_cnt_n = rel_cnt;
        retry_n   = retry_cnt;
        rst_out_n = '1;
        ready_n   = 1'b0;
        go_rst    = 1'b0;
        go_rel    = 1'b0;
        go_run    = 1'b0;

        case (state)
            S_PLL_RST: begin
                if (relock_req) begin
                    go_rst = 1'b1;
                end else if (rst_cnt == RST_LAST) begin
                    state_n  = S_WAIT_LOCK;
                    to_cnt_n = '0;
                end else begin
                    rst_cnt_n = rst_cnt + RST_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                to_cnt_n = to_inc;
                if (relock_req) begin
                    go_rst = 1'b1;
                end else if (lock_s) begin
                    if (STABLE_CYCLES == 1) begin
                        go_rel = 1'b1;
                    end else begin
                        state_n   = S_STABLE;
                        stb_cnt_n = STB_W'(1);
                    end
                end else if (to_inc == TO_MAX) begin
                    retry_n = retry_sat;
                    if (retry_sat == RETRY_LIMIT) begin
                        state_n = S_FAIL;
                    end else begin
                        go_rst = 1'b1;
                    end
                end
            end
            S_STABLE: begin
                // The timeout counter is left alone so lock flicker cannot extend the wait.
                if (relock_req) begin
                    go_rst = 1'b1;
                end else if (!lock_s) begin
                    state_n = S_WAIT_LOCK;
                end else if (stb_inc == STB_MAX) begin
                    go_rel = 1'b1;
                end else begin
                    stb_cnt_n = stb_inc;
                end
            end
            S_RELEASE: begin
                if (relock_req || !lock_s) begin
                    go_rst = 1'b1;
                end else if (rel_inc == REL_LAST) begin
                    go_run = 1'b1;
                end else begin
                    rel_cnt_n = rel_inc;
                    for (int i = 0; i < NUM_CH; i++) begin
                        rst_out_n[i] = (int'(rel_inc) < i * CH_STAGGER);
                    end
                end
            end
            S_RUN: begin
                if (relock_req || !lock_s) begin
                    go_rst = 1'b1;
                end else begin
                    rst_out_n = '0;
                    ready_n   = 1'b1;
                end
            end
            S_FAIL: begin
                if (relock_req) begin
                    retry_n = '0;
                    go_rst  = 1'b1;
                end
            end
            default: begin
                go_rst = 1'b1;
            end
        endcase

        if (go_rel) begin
            if (NUM_CH == 1) begin
                go_run = 1'b1;
            end else begin
                state_n   = S_RELEASE;
                rel_cnt_n = '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    rst_out_n[i] = (i != 0);
                end
            end
        end

        if (go_run) begin
            state_n   = S_RUN;
            rst_out_n = '0;
            ready_n   = 1'b1;
            retry_n   = '0;
        end

        if (go_rst) begin
            state_n   = S_PLL_RST;
            rst_cnt_n = '0;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: a phase-level model predicts every output change from the
// lock/relock traces; a monitor pops and compares each change the DUT makes.
module tb_pll_lock_supervisor;

    localparam int NUM_CH         = 3;
    localparam int PLL_RST_CYCLES = 4;
    localparam int TIMEOUT_CYCLES = 32;
    localparam int STABLE_CYCLES  = 8;
    localparam int MAX_RETRIES    = 3;
    localparam int CH_STAGGER     = 2;
    localparam int MAXN           = 2000;
    localparam logic [9:0] RESET_VEC = {1'b1, 3'b111, 1'b0, 1'b0, 4'd0};

    logic              clk        = 1'b0;
    logic              reset      = 1'b1;
    logic              lock       = 1'b0;
    logic              relock_req = 1'b0;
    logic              pll_reset;
    logic [NUM_CH-1:0] rst_out;
    logic              ready;
    logic              fail;
    logic [3:0]        retry_cnt;

    pll_lock_supervisor #(
        .NUM_CH         (NUM_CH),
        .PLL_RST_CYCLES (PLL_RST_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES),
        .CH_STAGGER     (CH_STAGGER)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lock       (lock),
        .relock_req (relock_req),
        .pll_reset  (pll_reset),
        .rst_out    (rst_out),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [9:0] vec;
    } ev_t;

    typedef enum {M_RESET, M_LOCKWAIT, M_RELEASE, M_RUN, M_FAIL} mphase_t;

    ev_t        sb_q[$];
    bit         lock_tr   [0:MAXN];
    bit         relock_tr [0:MAXN];
    logic [9:0] exp_vec   [0:MAXN];
    int         n_len     = 0;
    int         n_checks  = 0;
    int         n_fail    = 0;
    bit         mon_start = 1'b0;
    bit         mon_stop  = 1'b0;

    function automatic logic [9:0] dutVec();
        return {pll_reset, rst_out, ready, fail, retry_cnt};
    endfunction

    // Lock as seen by the supervisor after its two-flop synchroniser.
    function automatic bit lks(int p);
        return (p >= 2) ? lock_tr[p-2] : 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic appendSeg(input int len, input bit v);
        for (int i = 0; i < len; i++) begin
            if (n_len < MAXN) begin
                lock_tr[n_len]   = v;
                relock_tr[n_len] = 1'b0;
                n_len++;
            end
        end
    endtask

    task automatic addRelock(input bit v);
        if (n_len < MAXN) begin
            lock_tr[n_len]   = v;
            relock_tr[n_len] = 1'b1;
            n_len++;
        end
    endtask

    // Walks the traces phase by phase: reset pulse, lock search (wait cycles and the
    // current run of lock highs), staggered release, run, fail.
    task automatic runModel();
        int       t, retries, k, w, run, j;
        bit       done;
        logic [2:0] rs;
        mphase_t  ph;
        t       = 0;
        retries = 0;
        ph      = M_RESET;
        lock_tr[n_len]   = lock_tr[n_len-1];
        relock_tr[n_len] = 1'b0;
        while (t <= n_len) begin
            case (ph)
                M_RESET: begin
                    k = 0;
                    while (k < PLL_RST_CYCLES && t <= n_len) begin
                        exp_vec[t] = {1'b1, 3'b111, 1'b0, 1'b0, 4'(retries)};
                        k = relock_tr[t] ? 0 : k + 1;
                        t++;
                    end
                    ph = M_LOCKWAIT;
                end
                M_LOCKWAIT: begin
                    w = 0; run = 0; done = 1'b0;
                    while (!done && t <= n_len) begin
                        exp_vec[t] = {1'b0, 3'b111, 1'b0, 1'b0, 4'(retries)};
                        if (relock_tr[t]) begin
                            ph = M_RESET; done = 1'b1;
                        end else if (run == 0) begin
                            w = (w < TIMEOUT_CYCLES) ? w + 1 : w;
                            if (lks(t)) begin
                                run = 1;
                                if (run == STABLE_CYCLES) begin ph = M_RELEASE; done = 1'b1; end
                            end else if (w >= TIMEOUT_CYCLES) begin
                                retries = (retries < 15) ? retries + 1 : retries;
                                ph = (retries == MAX_RETRIES) ? M_FAIL : M_RESET;
                                done = 1'b1;
                            end
                        end else if (!lks(t)) begin
                            run = 0;
                        end else begin
                            run++;
                            if (run == STABLE_CYCLES) begin ph = M_RELEASE; done = 1'b1; end
                        end
                        t++;
                    end
                end
                M_RELEASE: begin
                    j = 0; done = 1'b0;
                    while (!done && t <= n_len) begin
                        for (int i = 0; i < NUM_CH; i++) rs[i] = (j < i * CH_STAGGER);
                        exp_vec[t] = {1'b0, rs, 1'b0, 1'b0, 4'(retries)};
                        if (relock_tr[t] || !lks(t)) begin
                            ph = M_RESET; done = 1'b1;
                        end else if (j == (NUM_CH - 1) * CH_STAGGER - 1) begin
                            ph = M_RUN; retries = 0; done = 1'b1;
                        end
                        j++;
                        t++;
                    end
                end
                M_RUN: begin
                    exp_vec[t] = {1'b0, 3'b000, 1'b1, 1'b0, 4'(retries)};
                    if (relock_tr[t] || !lks(t)) ph = M_RESET;
                    t++;
                end
                default: begin
                    exp_vec[t] = {1'b1, 3'b111, 1'b0, 1'b1, 4'(retries)};
                    if (relock_tr[t]) begin
                        retries = 0;
                        ph = M_RESET;
                    end
                    t++;
                end
            endcase
        end
    endtask

    // Drives one cycle of stimulus and queues the output change it is expected to cause.
    task automatic applyStimulus(input int p);
        lock       = lock_tr[p];
        relock_req = relock_tr[p];
        if (exp_vec[p+1] !== exp_vec[p]) sb_q.push_back('{cyc: p + 1, vec: exp_vec[p+1]});
    endtask

    initial begin : monitor
        logic [9:0] cur, prev;
        int         p;
        ev_t        e;
        wait (mon_start);
        #1;
        cur = dutVec();
        checkOutput("reset_values", 32'(cur), 32'(RESET_VEC));
        prev = cur;
        p    = 0;
        forever begin
            @(negedge clk);
            #1;
            if (mon_stop) break;
            p++;
            cur = dutVec();
            if (cur !== prev) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_change: got %0h at cycle %0d, expected no change", cur, p);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("change_cycle", 32'(p), 32'(e.cyc));
                    checkOutput("change_value", 32'(cur), 32'(e.vec));
                end
                prev = cur;
            end
        end
    end

    initial begin : driver
        int mark, p0, rstart;

        // Bring-up, lock loss in RUN, full timeout-to-FAIL and recovery.
        appendSeg(40, 1'b1);
        appendSeg(3, 1'b0);
        appendSeg(40, 1'b1);
        appendSeg(130, 1'b0);
        addRelock(1'b0);
        appendSeg(20, 1'b0);
        appendSeg(40, 1'b1);
        // Lock glitch while qualifying.
        addRelock(1'b1);
        appendSeg(4, 1'b0);
        appendSeg(5, 1'b1);
        appendSeg(1, 1'b0);
        appendSeg(40, 1'b1);
        // Relock coinciding with lock loss during the staggered release.
        mark = n_len;
        addRelock(1'b1);
        appendSeg(4, 1'b0);
        appendSeg(30, 1'b1);
        runModel();
        p0 = -1;
        for (int p = mark; p < n_len; p++) begin
            if (p0 < 0 && exp_vec[p][8:6] == 3'b110) p0 = p;
        end
        if (p0 > 0) begin
            relock_tr[p0+1] = 1'b1;
            for (int p = p0 - 1; p <= p0 + 8; p++) lock_tr[p] = 1'b0;
        end
        appendSeg(40, 1'b1);
        // Random lock flicker with occasional relock requests.
        rstart = n_len;
        while (n_len < rstart + 300) begin
            if ($urandom_range(0, 39) == 0) addRelock(1'($urandom_range(0, 1)));
            appendSeg(int'($urandom_range(1, 48)), ($urandom_range(0, 3) != 0));
        end
        addRelock(1'b1);
        appendSeg(60, 1'b1);
        runModel();

        repeat (3) @(negedge clk);
        reset = 1'b0;
        applyStimulus(0);
        mon_start = 1'b1;
        for (int p = 1; p < n_len; p++) begin
            @(negedge clk);
            applyStimulus(p);
        end
        @(negedge clk);
        relock_req = 1'b0;
        #2 mon_stop = 1'b1;
        #1;
        checkOutput("pending_events", 32'(sb_q.size()), 32'd0);
        checkOutput("ready_before_reset", 32'(ready), 32'(exp_vec[n_len][5]));

        // Asynchronous reset mid-cycle while running.
        reset = 1'b1;
        #1;
        checkOutput("async_pll_reset", 32'(pll_reset), 32'd1);
        checkOutput("async_rst_out", 32'(rst_out), 32'd7);
        checkOutput("async_ready", 32'(ready), 32'd0);
        checkOutput("async_fail", 32'(fail), 32'd0);
        checkOutput("async_retry_cnt", 32'(retry_cnt), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Single-clock supervisor for a Gowin rPLL, e.g. the HDMI 720p pixel/TMDS PLL. Runs on the PLL reference clock (27 MHz).
- Drives the PLL RESET pin and sequences the PLL through reset, lock wait and lock qualification.
- Retries on lock timeout; after MAX_RETRIES timeouts it latches a fail flag.
- Releases NUM_CH downstream reset channels in a staggered order, e.g. TMDS serialiser, video timing and audio. Reasserts all channels immediately on lock loss or on a relock request.

Parameters:
- NUM_CH, 3: number of downstream reset outputs, 1..8.
- PLL_RST_CYCLES, 16: clk cycles pll_reset is held high per reset attempt, ≥1.
- TIMEOUT_CYCLES, 27000: maximum clk cycles in WAIT_LOCK before a retry, ≥2.
- STABLE_CYCLES, 2700: consecutive synchronised-lock-high cycles required before release, ≥1.
- MAX_RETRIES, 4: lock timeouts tolerated before entering FAIL, 1..15.
- CH_STAGGER, 8: clk cycles between successive channel releases, ≥1.

Ports:
- clk, input, 1: PLL reference clock; the only clock.
- reset, input, 1: asynchronous, active-high reset.
- lock, input, 1: raw rPLL LOCK. Asynchronous to clk; synchronised internally with 2 flops.
- relock_req, input, 1: single-cycle request to restart the PLL. Also the only exit from FAIL.
- pll_reset, output, 1: to rPLL RESET, active high.
- rst_out, output, NUM_CH: downstream resets, active high; bit 0 is released first.
- ready, output, 1: high only in RUN with every channel released.
- fail, output, 1: high while in FAIL.
- retry_cnt, output, 4: timeouts since the last successful RUN entry or relock_req.

Behaviour:
- **Reset values** (asynchronous): state=PLL_RST, pll_reset=1, rst_out=all 1, ready=0, fail=0, retry_cnt=0, all counters=0, lock synchroniser=0. All outputs are registered.
- **Lock synchroniser:** lock_s is lock delayed by 2 clk flops. Every reference to lock below means lock_s.
- **PLL_RST:**
  - pll_reset=1 for exactly PLL_RST_CYCLES cycles; rst_out=all 1.
  - Then go to WAIT_LOCK; pll_reset goes 0 in the first WAIT_LOCK cycle.
- **WAIT_LOCK:**
  - The timeout counter increments every cycle.
  - lock_s=1 → STABLE, with the stable counter counting this cycle as 1.
  - Counter reaches TIMEOUT_CYCLES with lock_s still 0 → retry_cnt+1 (saturates at 15). If the new value equals MAX_RETRIES → FAIL; otherwise → PLL_RST.
- **STABLE:**
  - lock_s=0 → WAIT_LOCK. The timeout counter continues and is not cleared.
  - Stable counter reaches STABLE_CYCLES → RELEASE.
- **RELEASE:**
  - rst_out[0] deasserts in the first RELEASE cycle.
  - rst_out[i] deasserts i*CH_STAGGER cycles after rst_out[0].
  - After rst_out[NUM_CH-1] deasserts → RUN. ready=1 in the same cycle as the last release; retry_cnt clears to 0 on RUN entry.
  - lock_s=0 during RELEASE → all rst_out reasserted next cycle → PLL_RST.
- **RUN:** lock_s=0 or relock_req=1 → next cycle: rst_out=all 1, ready=0, state PLL_RST with pll_reset=1.
- **FAIL:**
  - pll_reset=1 (PLL held in reset), rst_out=all 1, fail=1.
  - relock_req=1 → fail=0, retry_cnt=0 → PLL_RST.
- **relock_req in PLL_RST/WAIT_LOCK/STABLE/RELEASE:** restart PLL_RST from its first cycle. retry_cnt is unchanged except in FAIL.
- **Simultaneous events:** relock_req has priority over lock_s changes and timeout in the same cycle.
- **Counters:**
  - Widths are $clog2(max+1) of their respective parameter.
  - Each counter clears on entry to its state; no counter wraps.
  - The timeout and stable counters saturate at their terminal count.
- **Invariant:** rst_out bits deassert strictly in index order and are never partially reasserted; any reassertion is all bits in the same cycle.
- **Reset mid-operation:** asynchronous return to the reset values from any state.

Test Plan:
Common parameters: NUM_CH=3, PLL_RST_CYCLES=4, TIMEOUT_CYCLES=32, STABLE_CYCLES=8, MAX_RETRIES=3, CH_STAGGER=2.
1. **Clean bring-up.** lock tied 1, reset released → pll_reset high exactly 4 cycles; rst_out[0] falls 8+ cycles after lock_s is first high; rst_out[1], [2] follow at +2 and +4 cycles; ready=1 with rst_out[2]=0; retry_cnt=0.
2. **Timeout retries.** lock tied 0 → 3 pll_reset pulses of 4 cycles each, spaced by a 32-cycle WAIT_LOCK; retry_cnt steps 1, 2, 3; fail=1 and pll_reset=1 held. relock_req pulse → fail=0, retry_cnt=0, new 4-cycle pll_reset.
3. **Lock glitch during STABLE.** lock high 5 cycles, low 1, then high → no release until 8 consecutive lock_s highs; rst_out stays 3'b111 throughout.
4. **Lock loss in RUN.** After ready=1, drop lock → 2 sync cycles + 1: rst_out=3'b111, ready=0, pll_reset=1; full re-sequence follows.
5. **Relock priority.** In RELEASE after rst_out[0]=0, pulse relock_req in the same cycle lock drops → next cycle rst_out=3'b111, state PLL_RST, retry_cnt unchanged.
6. **Asynchronous reset in RUN.** Assert reset → immediately pll_reset=1, rst_out=3'b111, ready=0, fail=0, retry_cnt=0.
